// File: rtl/video_pattern_gen.sv
// Video raster timing plus selectable RGB test patterns (ramp, bars, grid, black).
// Define PATTERN_NOISE_EN to add saturating LFSR dither noise on active pixels.
module video_pattern_gen #(
  parameter int unsigned COLOR_W      = 6,
  parameter int unsigned H_TOTAL      = 768,
  parameter int unsigned H_ACT_START  = 20,
  parameter int unsigned H_ACT_END    = 680,
  parameter int unsigned H_SYNC_START = 707,
  parameter int unsigned V_TOTAL      = 312,
  parameter int unsigned V_ACT_START  = 10,
  parameter int unsigned V_ACT_END    = 306,
  parameter int unsigned V_SYNC_START = 308,
  parameter int unsigned SCROLL_STEP  = 6
) (
  input  logic               clk_pix,
  input  logic               reset_n,
  input  logic               ce_pix,
  input  logic [1:0]         mode,
  output logic [9:0]         hcount,
  output logic [8:0]         vcount,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B,
  output logic               HS,
  output logic               VS,
  output logic               HBlank,
  output logic               VBlank,
  output logic               DE,
  output logic               CSYNC,
  output logic               frame_start
);

  localparam int unsigned BAR_W = (H_ACT_END - H_ACT_START + 1) / 8;

  localparam logic [9:0] HTotM1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] HActS  = 10'(H_ACT_START);
  localparam logic [9:0] HActE  = 10'(H_ACT_END);
  localparam logic [9:0] HSyncS = 10'(H_SYNC_START);
  localparam logic [8:0] VTotM1 = 9'(V_TOTAL - 1);
  localparam logic [8:0] VActS  = 9'(V_ACT_START);
  localparam logic [8:0] VActE  = 9'(V_ACT_END);
  localparam logic [8:0] VSyncS = 9'(V_SYNC_START);
  localparam logic [9:0] BarWM1 = 10'(BAR_W - 1);
  localparam logic [3:0] HActS4 = 4'(H_ACT_START);
  localparam logic [3:0] VActS4 = 4'(V_ACT_START);

  logic [9:0] hc_q, hc_d;
  logic [8:0] vc_q, vc_d;
  logic [9:0] scroll_q, scroll_d;
  logic [1:0] mode_q, mode_d;
  logic [9:0] bar_pos_q, bar_pos_d;
  logic [2:0] bar_idx_q, bar_idx_d;

  logic h_wrap, v_wrap, h_act;
  logic hblank, vblank, hs, vs, de;
  logic [3:0] xa4, ya4;
  logic [9:0] idx;
  logic [COLOR_W-1:0] gray, r_pat, g_pat, b_pat, r_fin, g_fin, b_fin;
  logic unused_idx;

  assign h_wrap = (hc_q == HTotM1);
  assign v_wrap = (vc_q == VTotM1);
  assign h_act  = (hc_q >= HActS) && (hc_q <= HActE);

  assign hblank = (hc_q < HActS) || (hc_q > HActE);
  assign vblank = (vc_q < VActS) || (vc_q > VActE);
  assign hs     = (hc_q >= HSyncS);
  assign vs     = (vc_q >= VSyncS);
  assign de     = !hblank && !vblank;

  // Only the low nibble of the active-relative coordinates matters for the grid.
  assign xa4 = hc_q[3:0] - HActS4;
  assign ya4 = vc_q[3:0] - VActS4;

  // Triangle ramp: rises over idx 0..511, falls over 512..1023.
  assign idx        = scroll_q + {vc_q[7:0], 2'b00};
  assign gray       = idx[9] ? ~idx[8 -: COLOR_W] : idx[8 -: COLOR_W];
  assign unused_idx = ^idx[8-COLOR_W:0];

  always_comb begin
    hc_d      = hc_q;
    vc_d      = vc_q;
    scroll_d  = scroll_q;
    mode_d    = mode_q;
    bar_pos_d = bar_pos_q;
    bar_idx_d = bar_idx_q;
    if (h_wrap) begin
      hc_d      = '0;
      bar_pos_d = '0;
      bar_idx_d = '0;
      if (v_wrap) begin
        vc_d     = '0;
        scroll_d = scroll_q + 10'(SCROLL_STEP);
        mode_d   = mode;
      end else begin
        vc_d = vc_q + 9'd1;
      end
    end else begin
      hc_d = hc_q + 10'd1;
      if (h_act) begin
        if (bar_pos_q == BarWM1) begin
          bar_pos_d = '0;
          if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_pos_d = bar_pos_q + 10'd1;
        end
      end
    end
  end

  always_comb begin
    r_pat = '0;
    g_pat = '0;
    b_pat = '0;
    case (mode_q)
      2'd0: begin
        r_pat = gray;
        g_pat = gray;
        b_pat = gray;
      end
      2'd1: begin
        // Bar order 111,110,011,010,101,100,001,000 decodes to these index bits.
        r_pat = {COLOR_W{~bar_idx_q[1]}};
        g_pat = {COLOR_W{~bar_idx_q[2]}};
        b_pat = {COLOR_W{~bar_idx_q[0]}};
      end
      2'd2: begin
        if (xa4 == 4'd0 || ya4 == 4'd0) begin
          r_pat = '1;
          g_pat = '1;
          b_pat = '1;
        end
      end
      default: ;
    endcase
  end

`ifdef PATTERN_NOISE_EN
  logic [22:0]        lfsr_q, lfsr_d;
  logic [COLOR_W-1:0] noise;

  function automatic logic [COLOR_W-1:0] sat_sub(input logic [COLOR_W-1:0] c,
                                                 input logic [COLOR_W-1:0] n);
    return (c >= n) ? c - n : '0;
  endfunction

  assign lfsr_d = {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]};
  assign noise  = {lfsr_q[0], lfsr_q[1], {(COLOR_W-2){lfsr_q[2]}}};
  assign r_fin  = sat_sub(r_pat, noise);
  assign g_fin  = sat_sub(g_pat, noise);
  assign b_fin  = sat_sub(b_pat, noise);

  always_ff @(posedge clk_pix) begin
    if (!reset_n) begin
      lfsr_q <= 23'h000001;
    end else if (ce_pix) begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign r_fin = r_pat;
  assign g_fin = g_pat;
  assign b_fin = b_pat;
`endif

  always_ff @(posedge clk_pix) begin
    if (!reset_n) begin
      hc_q        <= '0;
      vc_q        <= '0;
      scroll_q    <= '0;
      mode_q      <= '0;
      bar_pos_q   <= '0;
      bar_idx_q   <= '0;
      hcount      <= '0;
      vcount      <= '0;
      R           <= '0;
      G           <= '0;
      B           <= '0;
      HS          <= 1'b0;
      VS          <= 1'b0;
      HBlank      <= 1'b0;
      VBlank      <= 1'b0;
      DE          <= 1'b0;
      CSYNC       <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce_pix) begin
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      scroll_q    <= scroll_d;
      mode_q      <= mode_d;
      bar_pos_q   <= bar_pos_d;
      bar_idx_q   <= bar_idx_d;
      hcount      <= hc_q;
      vcount      <= vc_q;
      R           <= de ? r_fin : '0;
      G           <= de ? g_fin : '0;
      B           <= de ? b_fin : '0;
      HS          <= hs;
      VS          <= vs;
      HBlank      <= hblank;
      VBlank      <= vblank;
      DE          <= de;
      CSYNC       <= ~(hs ^ vs);
      frame_start <= (hc_q == 10'd0) && (vc_q == 9'd0);
    end
  end

endmodule
